// File: rtl/trace_pkg.sv
// Shared types and constants for the cover-trace replay engine.
package trace_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    localparam int unsigned STEP_CNT_W = 32;

    localparam logic [STEP_CNT_W-1:0] STEP_CNT_RST = '0;
    localparam logic [STEP_CNT_W-1:0] STEP_CNT_MAX = '1;

    // Saturating increment for the issued-entry counter.
    function automatic logic [STEP_CNT_W-1:0] sat_inc(input logic [STEP_CNT_W-1:0] v);
        return (v == STEP_CNT_MAX) ? v : v + STEP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cover_trace_player_if.sv
// Control/trace bus between a host (master) and the replay engine (slave).
interface cover_trace_player_if #(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned STEP_W = 8
);
    import trace_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [IN_W-1:0]       wr_data;
    logic [AW-1:0]         last_idx;
    logic [STEP_W-1:0]     step_len;
    logic                  loop_en;
    logic                  pause;
    logic                  start;
    logic [IN_W-1:0]       pi_out;
    logic                  pi_valid;
    logic                  busy;
    logic                  done;
    logic [STEP_CNT_W-1:0] step_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, last_idx, step_len, loop_en, pause, start,
        input  pi_out, pi_valid, busy, done, step_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, last_idx, step_len, loop_en, pause, start,
        output pi_out, pi_valid, busy, done, step_cnt
    );

endinterface

// File: rtl/trace_mem.sv
// DEPTH x IN_W simple dual-port trace RAM: one write port, one registered read port.
module trace_mem #(
    parameter int unsigned IN_W  = 7,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic            clock,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [IN_W-1:0] wdata,
    input  logic            re,
    input  logic [AW-1:0]   raddr,
    output logic [IN_W-1:0] rdata
);

    logic [IN_W-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port, one cycle latency, holds its value while re is low.
    always_ff @(posedge clock) begin
        if (re) begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/cover_trace_player.sv
// Replays stored primary-input vectors, one entry per (step_len+1) cycles.
// The RAM read is issued one load ahead so the output register always has the
// next entry waiting, which allows step_len=0 and gap-free wrap in loop mode.
module cover_trace_player
    import trace_pkg::*;
#(
    parameter int unsigned IN_W   = 7,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned STEP_W = 8
) (
    input  logic clock,
    input  logic reset,
    cover_trace_player_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);

    state_e                state_q, state_d;
    logic [AW-1:0]         last_q, last_d;
    logic [AW-1:0]         nxt_q, nxt_d;
    logic [STEP_W-1:0]     len_q, len_d;
    logic [STEP_W-1:0]     hold_q, hold_d;
    logic                  cur_last_q, cur_last_d;
    logic [IN_W-1:0]       pi_out_q, pi_out_d;
    logic                  pi_valid_q, pi_valid_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic                  byp_vld_q, byp_vld_d;
    logic [IN_W-1:0]       byp_data_q, byp_data_d;

    logic                  mem_we_c;
    logic                  rd_en_c;
    logic [AW-1:0]         rd_addr_c;
    logic [AW-1:0]         nxt_succ_c;
    logic [IN_W-1:0]       mem_rdata;
    logic [IN_W-1:0]       rdata_c;
    logic                  load_c;

    // Writes are only accepted outside replay.
    assign mem_we_c   = bus.wr_en & ~busy_q;
    // A write landing on entry 0 in the start cycle must win over the stale read.
    assign rdata_c    = byp_vld_q ? byp_data_q : mem_rdata;
    assign nxt_succ_c = (nxt_q == last_q) ? '0 : nxt_q + AW'(1);

    trace_mem #(
        .IN_W  (IN_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clock (clock),
        .we    (mem_we_c),
        .waddr (bus.wr_addr),
        .wdata (bus.wr_data),
        .re    (rd_en_c),
        .raddr (rd_addr_c),
        .rdata (mem_rdata)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, entry sequencing, prefetch control and output next values.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        nxt_d      = nxt_q;
        len_d      = len_q;
        hold_d     = hold_q;
        cur_last_d = cur_last_q;
        pi_out_d   = pi_out_q;
        pi_valid_d = pi_valid_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        byp_vld_d  = byp_vld_q;
        byp_data_d = byp_data_q;
        rd_en_c    = 1'b0;
        rd_addr_c  = nxt_succ_c;
        load_c     = 1'b0;

        case (state_q)
            IDLE: begin
                rd_addr_c = '0;
                if (bus.start) begin
                    state_d    = PLAY;
                    busy_d     = 1'b1;
                    last_d     = bus.last_idx;
                    len_d      = bus.step_len;
                    nxt_d      = '0;
                    step_cnt_d = STEP_CNT_RST;
                    rd_en_c    = 1'b1;
                    byp_vld_d  = mem_we_c && (bus.wr_addr == '0);
                    byp_data_d = bus.wr_data;
                end
            end
            PLAY: begin
                if (!bus.pause) begin
                    if (!pi_valid_q) begin
                        load_c = 1'b1;
                    end else if (hold_q != '0) begin
                        hold_d = hold_q - STEP_W'(1);
                    end else if (cur_last_q && !bus.loop_en) begin
                        state_d    = IDLE;
                        busy_d     = 1'b0;
                        pi_valid_d = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        load_c = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_c) begin
            pi_out_d   = rdata_c;
            pi_valid_d = 1'b1;
            hold_d     = len_q;
            nxt_d      = nxt_succ_c;
            cur_last_d = (nxt_q == last_q);
            step_cnt_d = sat_inc(step_cnt_q);
            rd_en_c    = 1'b1;
            byp_vld_d  = 1'b0;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_q     <= '0;
            nxt_q      <= '0;
            len_q      <= '0;
            hold_q     <= '0;
            cur_last_q <= 1'b0;
            pi_out_q   <= '0;
            pi_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_cnt_q <= STEP_CNT_RST;
            byp_vld_q  <= 1'b0;
            byp_data_q <= '0;
        end else begin
            last_q     <= last_d;
            nxt_q      <= nxt_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            cur_last_q <= cur_last_d;
            pi_out_q   <= pi_out_d;
            pi_valid_q <= pi_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_cnt_q <= step_cnt_d;
            byp_vld_q  <= byp_vld_d;
            byp_data_q <= byp_data_d;
        end
    end

    assign bus.pi_out   = pi_out_q;
    assign bus.pi_valid = pi_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.step_cnt = step_cnt_q;

endmodule

// File: tb/tb_cover_trace_player.sv
// Scoreboard bench for cover_trace_player: stimulus pushes expected per-cycle
// vectors, done pulses and idle snapshots; a negedge monitor pops and compares.
module tb_cover_trace_player;

    localparam int unsigned IN_W   = 7;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned STEP_W = 8;

    typedef struct {
        int          cyc;
        logic [6:0]  vec;
        logic [31:0] cnt;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   end_req = 1'b0;

    exp_t exp_q[$];
    exp_t done_q[$];
    exp_t idle_q[$];

    cover_trace_player_if #(.IN_W(IN_W), .DEPTH(DEPTH), .STEP_W(STEP_W)) bus ();

    cover_trace_player #(.IN_W(IN_W), .DEPTH(DEPTH), .STEP_W(STEP_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at cycle %0d", name, got, want, cyc);
        end
    endtask

    // Monitor: compares everything the DUT presents against the queues.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (bus.pi_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 32'(bus.pi_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("vec_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pi_out", 32'(bus.pi_out), 32'(e.vec));
                    chk("step_cnt", bus.step_cnt, e.cnt);
                    chk("busy_in_play", 32'(bus.busy), 32'd1);
                end
            end
            if (bus.done === 1'b1) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(bus.done), 32'd0);
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_pi_out", 32'(bus.pi_out), 32'(e.vec));
                    chk("done_step_cnt", bus.step_cnt, e.cnt);
                    chk("done_busy", 32'(bus.busy), 32'd0);
                    chk("done_pi_valid", 32'(bus.pi_valid), 32'd0);
                end
            end
            if (idle_q.size() > 0 && idle_q[0].cyc <= cyc) begin
                e = idle_q.pop_front();
                chk("idle_cycle", 32'(cyc), 32'(e.cyc));
                chk("idle_pi_out", 32'(bus.pi_out), 32'(e.vec));
                chk("idle_step_cnt", bus.step_cnt, e.cnt);
                chk("idle_busy", 32'(bus.busy), 32'd0);
                chk("idle_pi_valid", 32'(bus.pi_valid), 32'd0);
                chk("idle_done", 32'(bus.done), 32'd0);
            end
            if (cyc > 4000) begin
                chk("watchdog", 32'(cyc), 32'd4000);
                end_req = 1'b1;
            end
            if (end_req) begin
                chk("leftover_vec", 32'(exp_q.size()), 32'd0);
                chk("leftover_done", 32'(done_q.size()), 32'd0);
                chk("leftover_idle", 32'(idle_q.size()), 32'd0);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
    end

    task automatic push_run(input logic [6:0] v, input logic [31:0] c, input int first, input int n);
        exp_t t;
        for (int i = 0; i < n; i++) begin
            t.cyc = first + i;
            t.vec = v;
            t.cnt = c;
            exp_q.push_back(t);
        end
    endtask

    task automatic push_done(input int at, input logic [6:0] v, input logic [31:0] c);
        exp_t t;
        t.cyc = at;
        t.vec = v;
        t.cnt = c;
        done_q.push_back(t);
    endtask

    task automatic push_idle(input int at, input logic [6:0] v, input logic [31:0] c);
        exp_t t;
        t.cyc = at;
        t.vec = v;
        t.cnt = c;
        idle_q.push_back(t);
    endtask

    task automatic wr(input int a, input logic [6:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(a);
        bus.wr_data = d;
        @(negedge clock);
        bus.wr_en   = 1'b0;
    endtask

    task automatic start_run(input int last, input int len, input bit loop, output int e0);
        bus.last_idx = 4'(last);
        bus.step_len = 8'(len);
        bus.loop_en  = loop;
        bus.start    = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        bus.start    = 1'b0;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clock);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0 && idle_q.size() == 0) break;
            @(negedge clock);
        end
        @(negedge clock);
    endtask

    // Directed stimulus with hand-computed expectations.
    initial begin
        int e0;
        reset        = 1'b1;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.last_idx = '0;
        bus.step_len = '0;
        bus.loop_en  = 1'b0;
        bus.pause    = 1'b0;
        bus.start    = 1'b0;
        @(negedge clock);
        @(negedge clock);
        push_idle(cyc + 1, 7'h00, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        wr(0, 7'b1110110);
        wr(1, 7'h01);
        wr(2, 7'h7F);

        // Basic one-cycle-per-entry replay.
        start_run(2, 0, 1'b0, e0);
        push_run(7'h76, 32'd1, e0 + 1, 1);
        push_run(7'h01, 32'd2, e0 + 2, 1);
        push_run(7'h7F, 32'd3, e0 + 3, 1);
        push_done(e0 + 4, 7'h7F, 32'd3);
        push_idle(e0 + 6, 7'h7F, 32'd3);
        drain();

        // Hold each entry four cycles.
        start_run(2, 3, 1'b0, e0);
        push_run(7'h76, 32'd1, e0 + 1, 4);
        push_run(7'h01, 32'd2, e0 + 5, 4);
        push_run(7'h7F, 32'd3, e0 + 9, 4);
        push_done(e0 + 13, 7'h7F, 32'd3);
        drain();

        // Loop over two entries, then clear loop_en while entry 0 shows.
        start_run(1, 0, 1'b1, e0);
        push_run(7'h76, 32'd1, e0 + 1, 1);
        push_run(7'h01, 32'd2, e0 + 2, 1);
        push_run(7'h76, 32'd3, e0 + 3, 1);
        push_run(7'h01, 32'd4, e0 + 4, 1);
        push_run(7'h76, 32'd5, e0 + 5, 1);
        push_run(7'h01, 32'd6, e0 + 6, 1);
        push_done(e0 + 7, 7'h01, 32'd6);
        wait_until(e0 + 5);
        bus.loop_en = 1'b0;
        drain();

        // Pause for five cycles in the middle of entry 1.
        start_run(2, 3, 1'b0, e0);
        push_run(7'h76, 32'd1, e0 + 1, 4);
        push_run(7'h01, 32'd2, e0 + 5, 9);
        push_run(7'h7F, 32'd3, e0 + 14, 4);
        push_done(e0 + 18, 7'h7F, 32'd3);
        wait_until(e0 + 6);
        bus.pause = 1'b1;
        wait_until(e0 + 11);
        bus.pause = 1'b0;
        drain();

        // Writes and start during replay are ignored.
        start_run(2, 3, 1'b0, e0);
        push_run(7'h76, 32'd1, e0 + 1, 4);
        push_run(7'h01, 32'd2, e0 + 5, 4);
        push_run(7'h7F, 32'd3, e0 + 9, 4);
        push_done(e0 + 13, 7'h7F, 32'd3);
        wait_until(e0 + 2);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd0;
        bus.wr_data = 7'h55;
        bus.start   = 1'b1;
        @(negedge clock);
        bus.wr_addr = 4'd2;
        bus.wr_data = 7'h33;
        bus.start   = 1'b0;
        @(negedge clock);
        bus.wr_en   = 1'b0;
        drain();

        // Reset mid-replay, then a fresh replay from entry 0.
        start_run(2, 0, 1'b1, e0);
        push_run(7'h76, 32'd1, e0 + 1, 1);
        push_run(7'h01, 32'd2, e0 + 2, 1);
        wait_until(e0 + 2);
        reset = 1'b1;
        push_idle(e0 + 3, 7'h00, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        drain();
        start_run(2, 0, 1'b0, e0);
        push_run(7'h76, 32'd1, e0 + 1, 1);
        push_run(7'h01, 32'd2, e0 + 2, 1);
        push_run(7'h7F, 32'd3, e0 + 3, 1);
        push_done(e0 + 4, 7'h7F, 32'd3);
        drain();

        // Write and start together, single-entry trace held two cycles.
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_data  = 7'h2A;
        bus.last_idx = 4'd0;
        bus.step_len = 8'd1;
        bus.loop_en  = 1'b0;
        bus.start    = 1'b1;
        e0 = cyc + 1;
        @(negedge clock);
        bus.wr_en    = 1'b0;
        bus.start    = 1'b0;
        push_run(7'h2A, 32'd1, e0 + 1, 2);
        push_done(e0 + 3, 7'h2A, 32'd1);
        push_idle(e0 + 5, 7'h2A, 32'd1);
        drain();

        end_req = 1'b1;
    end

endmodule
